// File: rtl/ddr4_cmd_issuer.sv
// ddr4_cmd_issuer
//   Pulls one request at a time from the trace-driven request queue. It splits
//   the address into DRAM coordinates and issues the closed-page sequence
//   ACT -> RD/WR -> PRE. It waits out tRCD, tRAS, tRTP, tCWL+tBURST+tWR and
//   tRP before taking the next request.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     queue head holds a request
//   req_ready     issuer is idle and will take the head this cycle
//   req_op        0 read, 1 write, 2 instruction fetch, 3 read
//   req_addr      33-bit byte address (bits [2:0] unused)
//   cmd_valid     one-cycle command strobe
//   cmd_code      0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
//   cmd_bg/bank/row/col   coordinates of the latched request
//   done          one-cycle pulse on the cycle the issuer returns to idle
module ddr4_cmd_issuer #(
    parameter int TRCD   = 24,
    parameter int TRAS   = 52,
    parameter int TRTP   = 12,
    parameter int TCWL   = 20,
    parameter int TBURST = 4,
    parameter int TWR    = 20,
    parameter int TRP    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [32:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [14:0] cmd_row,
    output logic [10:0] cmd_col,
    output logic        done
);

    if (TRCD < 1 || TRCD > 255 || TRAS < 1 || TRAS > 255 ||
        TRTP < 1 || TRTP > 255 || TCWL < 1 || TCWL > 255 ||
        TBURST < 1 || TBURST > 255 || TWR < 1 || TWR > 255 ||
        TRP < 1 || TRP > 255) begin : g_param_err
        $fatal(1, "ddr4_cmd_issuer: timing parameters must lie in 1..255");
    end

    // Column-to-precharge wait. The tRAS term is whatever remains of tRAS
    // after tRCD has already elapsed between ACT and the column command.
    localparam int RAS_REM = (TRAS > TRCD) ? (TRAS - TRCD) : 0;
    localparam int WR_REC  = TCWL + TBURST + TWR;
    localparam int P_RD_I  = (TRTP > RAS_REM) ? TRTP : RAS_REM;
    localparam int P_WR_I  = (WR_REC > RAS_REM) ? WR_REC : RAS_REM;

    localparam logic [8:0] P_RD    = 9'(P_RD_I);
    localparam logic [8:0] P_WR    = 9'(P_WR_I);
    localparam logic [8:0] TRCD_W  = 9'(TRCD);
    localparam logic [8:0] TRP_W   = 9'(TRP);

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_COL,
        S_WAIT_PRE,
        S_PRE,
        S_WAIT_RP
    } state_t;

    state_t      state, state_next;
    logic [8:0]  cnt, cnt_next;
    logic        done_next;
    logic        xfer;
    logic [8:0]  p_wait;

    logic        lat_wr;
    logic [1:0]  lat_bg;
    logic [1:0]  lat_bank;
    logic [14:0] lat_row;
    logic [10:0] lat_col;

    assign req_ready = (state == S_IDLE) && !rst;
    assign xfer      = req_valid && req_ready;
    assign p_wait    = lat_wr ? P_WR : P_RD;

    // State register, wait counter, done pulse and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            lat_wr   <= 1'b0;
            lat_bg   <= '0;
            lat_bank <= '0;
            lat_row  <= '0;
            lat_col  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
            if (xfer) begin
                lat_wr   <= (req_op == 2'd1);
                lat_bg   <= req_addr[7:6];
                lat_bank <= req_addr[9:8];
                lat_row  <= req_addr[32:18];
                lat_col  <= {req_addr[17:10], req_addr[5:3]};
            end
        end
    end

    // Each wait state leaves on the cycle its count decrements to zero. A
    // delay of N cycles therefore puts the next command exactly N cycles after
    // the one that loaded the counter. A delay of 1 skips the wait state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) state_next = S_ACT;
            end
            S_ACT: begin
                cnt_next = TRCD_W - 9'd1;
                if (TRCD_W == 9'd1) state_next = S_COL;
                else                state_next = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                cnt_next = cnt - 9'd1;
                if (cnt <= 9'd1) state_next = S_COL;
            end
            S_COL: begin
                cnt_next = p_wait - 9'd1;
                if (p_wait == 9'd1) state_next = S_PRE;
                else                state_next = S_WAIT_PRE;
            end
            S_WAIT_PRE: begin
                cnt_next = cnt - 9'd1;
                if (cnt <= 9'd1) state_next = S_PRE;
            end
            S_PRE: begin
                cnt_next = TRP_W - 9'd1;
                if (TRP_W == 9'd1) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                cnt_next = cnt - 9'd1;
                if (cnt <= 9'd1) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command strobe is decoded from state. It is suppressed while rst is high,
    // so a reset arriving in ACT/COL/PRE issues nothing that cycle.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_code  = C_NOP;
        if (!rst) begin
            case (state)
                S_ACT: begin
                    cmd_valid = 1'b1;
                    cmd_code  = C_ACT;
                end
                S_COL: begin
                    cmd_valid = 1'b1;
                    cmd_code  = lat_wr ? C_WR : C_RD;
                end
                S_PRE: begin
                    cmd_valid = 1'b1;
                    cmd_code  = C_PRE;
                end
                default: begin
                    cmd_valid = 1'b0;
                    cmd_code  = C_NOP;
                end
            endcase
        end
    end

    assign cmd_bg   = lat_bg;
    assign cmd_bank = lat_bank;
    assign cmd_row  = lat_row;
    assign cmd_col  = lat_col;

endmodule
